// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle RV32I sequencer and its datapath / shared memory port.
interface multicycle_control_if;
    logic [31:0] instr;
    logic        alu_zero;
    logic        alu_lt;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [2:0]  imm_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_ctrl;
    logic [1:0]  result_src;
    logic        illegal;

    modport master (
        input  instr, alu_zero, alu_lt, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               imm_src, alu_src_a, alu_src_b, alu_ctrl, result_src, illegal
    );

    modport slave (
        output instr, alu_zero, alu_lt, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               imm_src, alu_src_a, alu_src_b, alu_ctrl, result_src, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Fetch/decode/execute/writeback sequencer for the multi-cycle RV32I core.
// Define ILLEGAL_TRAP_EN to park in a sticky TRAP state on unknown opcodes instead of skipping them.
module multicycle_control #(
    parameter int unsigned RESET_PC_HOLD = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    localparam logic [2:0] FMT_I = 3'd0, FMT_S = 3'd1, FMT_B = 3'd2, FMT_U = 3'd3, FMT_J = 3'd4;

    localparam logic [3:0] ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND  = 4'd2, ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8, ALU_SRA = 4'd9, ALU_PASS_B = 4'd10;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011, OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011, OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011, OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111, OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRC_A_PC  = 2'd0, SRC_A_OLD_PC = 2'd1, SRC_A_RS1 = 2'd2;
    localparam logic [1:0] SRC_B_RS2 = 2'd0, SRC_B_IMM    = 2'd1, SRC_B_FOUR = 2'd2;
    localparam logic [1:0] RES_ALU_OUT = 2'd0, RES_MEM = 2'd1, RES_ALU = 2'd2;

    localparam logic [1:0] HOLD_INIT = 2'(RESET_PC_HOLD);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
        S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_UPPER, S_TRAP
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] hold_q, hold_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       instr_unused;
    logic [3:0] arith_op;
    logic [3:0] branch_op;
    logic       branch_taken;

    assign opcode       = bus.instr[6:0];
    assign funct3       = bus.instr[14:12];
    assign funct7_5     = bus.instr[30];
    assign instr_unused = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            hold_q  <= HOLD_INIT;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // funct7[5] selects SUB only for register-register ops; shifts use it for both forms.
    always_comb begin
        arith_op = ALU_ADD;
        case (funct3)
            3'b000:  arith_op = (opcode == OPC_OP && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    always_comb begin
        branch_op    = ALU_SUB;
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = bus.alu_zero;
            3'b001:  branch_taken = !bus.alu_zero;
            3'b100:  begin branch_op = ALU_SLT;  branch_taken = bus.alu_lt;  end
            3'b101:  begin branch_op = ALU_SLT;  branch_taken = !bus.alu_lt; end
            3'b110:  begin branch_op = ALU_SLTU; branch_taken = bus.alu_lt;  end
            3'b111:  begin branch_op = ALU_SLTU; branch_taken = !bus.alu_lt; end
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        bus.mem_req    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.adr_src    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.imm_src    = FMT_I;
        bus.alu_src_a  = SRC_A_PC;
        bus.alu_src_b  = SRC_B_RS2;
        bus.alu_ctrl   = ALU_ADD;
        bus.result_src = RES_ALU_OUT;

        case (state_q)
            S_FETCH: begin
                if (hold_q != 2'd0) begin
                    hold_d = hold_q - 2'd1;
                end else begin
                    bus.mem_req    = 1'b1;
                    bus.alu_src_b  = SRC_B_FOUR;
                    bus.result_src = RES_ALU;
                    bus.ir_write   = bus.mem_ready;
                    bus.pc_write   = bus.mem_ready;
                    if (bus.mem_ready) state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // The precomputed target is reused by JAL, so it needs the J immediate there.
                bus.alu_src_a = SRC_A_OLD_PC;
                bus.alu_src_b = SRC_B_IMM;
                bus.imm_src   = (opcode == OPC_JAL) ? FMT_J : FMT_B;
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
                    OPC_OP:              state_d = S_EXEC_R;
                    OPC_OP_IMM:          state_d = S_EXEC_I;
                    OPC_BRANCH:          state_d = S_BRANCH;
                    OPC_JAL:             state_d = S_JAL;
                    OPC_JALR:            state_d = S_JALR;
                    OPC_LUI, OPC_AUIPC:  state_d = S_UPPER;
`ifdef ILLEGAL_TRAP_EN
                    default:             state_d = S_TRAP;
`else
                    default:             state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = SRC_A_RS1;
                bus.alu_src_b = SRC_B_IMM;
                bus.imm_src   = (opcode == OPC_STORE) ? FMT_S : FMT_I;
                state_d       = (opcode == OPC_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.adr_src = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.result_src = RES_MEM;
                state_d        = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_req   = 1'b1;
                bus.mem_write = 1'b1;
                bus.adr_src   = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                bus.alu_src_a = SRC_A_RS1;
                bus.alu_src_b = SRC_B_RS2;
                bus.alu_ctrl  = arith_op;
                state_d       = S_ALU_WB;
            end
            S_EXEC_I: begin
                bus.alu_src_a = SRC_A_RS1;
                bus.alu_src_b = SRC_B_IMM;
                bus.alu_ctrl  = arith_op;
                state_d       = S_ALU_WB;
            end
            S_ALU_WB: begin
                // JALR overwrote the ALU register with its target, so the link is recomputed live.
                bus.reg_write = 1'b1;
                if (opcode == OPC_JALR) begin
                    bus.alu_src_a  = SRC_A_OLD_PC;
                    bus.alu_src_b  = SRC_B_FOUR;
                    bus.result_src = RES_ALU;
                end
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a = SRC_A_RS1;
                bus.alu_src_b = SRC_B_RS2;
                bus.imm_src   = FMT_B;
                bus.alu_ctrl  = branch_op;
                bus.pc_write  = branch_taken;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                bus.alu_src_a = SRC_A_OLD_PC;
                bus.alu_src_b = SRC_B_FOUR;
                bus.imm_src   = FMT_J;
                bus.pc_write  = 1'b1;
                state_d       = S_ALU_WB;
            end
            S_JALR: begin
                bus.alu_src_a  = SRC_A_RS1;
                bus.alu_src_b  = SRC_B_IMM;
                bus.result_src = RES_ALU;
                bus.pc_write   = 1'b1;
                state_d        = S_ALU_WB;
            end
            S_UPPER: begin
                bus.imm_src   = FMT_U;
                bus.alu_src_b = SRC_B_IMM;
                if (opcode == OPC_LUI) begin
                    bus.alu_ctrl = ALU_PASS_B;
                end else begin
                    bus.alu_src_a = SRC_A_OLD_PC;
                end
                state_d = S_ALU_WB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal = (state_q == S_TRAP);
`else
    assign bus.illegal = 1'b0;
`endif
endmodule
